// File: rtl/lv1_dl_pkg.sv
// Shared types for the lv1 data-cache tag/MESI controller.
// No logic, no latency, no backpressure.
// Types only; imported by the controller and its PLRU helper.
package lv1_dl_pkg;

  typedef enum logic [1:0] {I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11} mesi_t;

  typedef enum logic [1:0] {NONE = 2'd0, BUS_RD = 2'd1, BUS_RDX = 2'd2, INVALIDATE = 2'd3} bus_op_t;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, WAIT_FILL = 2'd2} fsm_t;

endpackage

// File: rtl/plru_tree_lv1.sv
// Tree pseudo-LRU touch and victim select over one set's ASSOC-1 bits.
// Purely combinational, zero latency.
// No flow control; caller decides when to write bits_touched back.
module plru_tree_lv1 #(
  parameter int ASSOC     = 4,
  parameter int ASSOC_WID = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0]     bits,
  input  logic [ASSOC_WID-1:0] touch_way,
  output logic [ASSOC-2:0]     bits_touched,
  output logic [ASSOC_WID-1:0] victim_way
);

  // Heap-ordered nodes 1..ASSOC-1 live at bits[node-1]; 0 steers left.
  always_comb begin : victim_walk
    int node;
    node = 1;
    for (int l = 0; l < ASSOC_WID; l++) begin
      node = 2 * node + int'(bits[node-1]);
    end
    victim_way = ASSOC_WID'(node - ASSOC);
  end

  always_comb begin : touch_walk
    int tn;
    bits_touched = bits;
    tn = 1;
    for (int l = 0; l < ASSOC_WID; l++) begin
      bits_touched[tn-1] = ~touch_way[ASSOC_WID-1-l];
      tn = 2 * tn + int'(touch_way[ASSOC_WID-1-l]);
    end
  end

endmodule

// File: rtl/lv1_dl_mesi_tag_ctrl.sv
// N-way lv1 tag/MESI/PLRU controller: cpu lookup, victim select, fill install, snoop.
// Lookup result one cycle after accept; snoop result one cycle after snoop_valid.
// One lookup in flight: proc_req_ready only in IDLE; snoops always accepted.
module lv1_dl_mesi_tag_ctrl
  import lv1_dl_pkg::*;
#(
  parameter int ADDR_WID    = 32,
  parameter int ASSOC       = 4,
  parameter int ASSOC_WID   = 2,
  parameter int NUM_OF_SETS = 256,
  parameter int INDEX_WID   = 8,
  parameter int OFFSET_WID  = 6,
  parameter int TAG_WID     = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 proc_req_valid,
  output logic                 proc_req_ready,
  input  logic                 proc_req_wr,
  input  logic [ADDR_WID-1:0]  proc_req_addr,
  output logic                 proc_rsp_valid,
  output logic                 proc_rsp_hit,
  output logic [ASSOC_WID-1:0] proc_rsp_way,
  output logic [1:0]           proc_rsp_bus_op,
  output logic                 proc_rsp_vdirty,
  output logic [TAG_WID-1:0]   proc_rsp_vtag,
  input  logic                 fill_valid,
  input  logic                 fill_shared,
  input  logic                 snoop_valid,
  input  logic [1:0]           snoop_op,
  input  logic [ADDR_WID-1:0]  snoop_addr,
  output logic                 snoop_rsp_valid,
  output logic                 snoop_hit,
  output logic                 snoop_flush,
  output logic                 shared_local
);

  logic [TAG_WID-1:0] tag_q  [NUM_OF_SETS][ASSOC];
  mesi_t              mesi_q [NUM_OF_SETS][ASSOC];
  logic [ASSOC-2:0]   plru_q [NUM_OF_SETS];

  fsm_t state_q, state_d;
  logic                 req_wr_q;
  logic [INDEX_WID-1:0] p_idx;
  logic [TAG_WID-1:0]   p_tag;
  logic [ASSOC_WID-1:0] alloc_way_q;

  // Byte-offset bits never take part in tag or index matching.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{proc_req_addr[OFFSET_WID-1:0], snoop_addr[OFFSET_WID-1:0]};

  // Lookup side: hit way and lowest invalid way of the captured set.
  logic                 p_hit, p_free;
  logic [ASSOC_WID-1:0] p_hit_way, p_free_way, plru_victim, victim_way, p_way;
  logic [ASSOC-2:0]     plru_touched;

  always_comb begin
    p_hit = 1'b0; p_hit_way = '0; p_free = 1'b0; p_free_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!p_hit && mesi_q[p_idx][w] != I && tag_q[p_idx][w] == p_tag) begin
        p_hit = 1'b1; p_hit_way = ASSOC_WID'(w);
      end
      if (!p_free && mesi_q[p_idx][w] == I) begin
        p_free = 1'b1; p_free_way = ASSOC_WID'(w);
      end
    end
  end

  assign victim_way = p_free ? p_free_way : plru_victim;

  logic                 rsp_hit, rsp_vdirty;
  logic [ASSOC_WID-1:0] rsp_way;
  bus_op_t              rsp_op;
  logic [TAG_WID-1:0]   rsp_vtag;
  logic                 p_mesi_we, p_tag_we, p_plru_we;
  mesi_t                p_new;

  always_comb begin
    state_d = state_q;
    rsp_hit = 1'b0; rsp_way = '0; rsp_op = NONE; rsp_vdirty = 1'b0; rsp_vtag = '0;
    p_mesi_we = 1'b0; p_tag_we = 1'b0; p_plru_we = 1'b0; p_new = I;
    case (state_q)
      IDLE: if (proc_req_valid) state_d = LOOKUP;
      LOOKUP: begin
        state_d = WAIT_FILL;
        if (p_hit && (!req_wr_q || mesi_q[p_idx][p_hit_way] != S)) begin
          state_d   = IDLE;
          rsp_hit   = 1'b1;
          rsp_way   = p_hit_way;
          p_plru_we = 1'b1;
          p_mesi_we = req_wr_q;
          p_new     = M;
        end else if (p_hit) begin
          rsp_way = p_hit_way;
          rsp_op  = INVALIDATE;
        end else begin
          rsp_way    = victim_way;
          rsp_op     = req_wr_q ? BUS_RDX : BUS_RD;
          rsp_vdirty = (mesi_q[p_idx][victim_way] == M);
          rsp_vtag   = tag_q[p_idx][victim_way];
        end
      end
      WAIT_FILL: if (fill_valid) begin
        state_d   = IDLE;
        p_tag_we  = 1'b1;
        p_mesi_we = 1'b1;
        p_plru_we = 1'b1;
        p_new     = req_wr_q ? M : (fill_shared ? S : E);
      end
      default: state_d = IDLE;
    endcase
  end

  assign p_way = (state_q == WAIT_FILL) ? alloc_way_q : rsp_way;

  plru_tree_lv1 #(.ASSOC(ASSOC), .ASSOC_WID(ASSOC_WID)) u_plru (
    .bits         (plru_q[p_idx]),
    .touch_way    (p_way),
    .bits_touched (plru_touched),
    .victim_way   (plru_victim)
  );

  // Snoop side: locate line, derive downgrade and flush.
  logic [INDEX_WID-1:0] s_idx;
  logic [TAG_WID-1:0]   s_tag;
  logic                 s_hit, s_flush;
  logic [ASSOC_WID-1:0] s_way;
  mesi_t                s_old, s_new;

  assign s_idx = snoop_addr[OFFSET_WID +: INDEX_WID];
  assign s_tag = snoop_addr[ADDR_WID-1 -: TAG_WID];

  always_comb begin
    s_hit = 1'b0; s_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!s_hit && mesi_q[s_idx][w] != I && tag_q[s_idx][w] == s_tag) begin
        s_hit = 1'b1; s_way = ASSOC_WID'(w);
      end
    end
    s_old = mesi_q[s_idx][s_way];
    s_new = s_old;
    s_flush = 1'b0;
    case (bus_op_t'(snoop_op))
      BUS_RD:     begin s_flush = (s_old == M); if (s_old != I) s_new = S; end
      BUS_RDX:    begin s_flush = (s_old == M); s_new = I; end
      INVALIDATE: if (s_old == S) s_new = I;
      default:    ;
    endcase
  end

  logic snp_vld_q, snp_hit_q, snp_flush_q, snp_shared_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_wr_q     <= 1'b0;
      p_idx        <= '0;
      p_tag        <= '0;
      alloc_way_q  <= '0;
      snp_vld_q    <= 1'b0;
      snp_hit_q    <= 1'b0;
      snp_flush_q  <= 1'b0;
      snp_shared_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && proc_req_valid) begin
        req_wr_q <= proc_req_wr;
        p_idx    <= proc_req_addr[OFFSET_WID +: INDEX_WID];
        p_tag    <= proc_req_addr[ADDR_WID-1 -: TAG_WID];
      end
      if (state_q == LOOKUP) alloc_way_q <= rsp_way;
      snp_vld_q    <= snoop_valid;
      snp_hit_q    <= snoop_valid & s_hit;
      snp_flush_q  <= snoop_valid & s_hit & s_flush;
      snp_shared_q <= snoop_valid & s_hit & (bus_op_t'(snoop_op) == BUS_RD);
    end
  end

  // Snoop update first, proc update second: on a collision the proc write wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_OF_SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) mesi_q[s][w] <= I;
      end
    end else begin
      if (snoop_valid && s_hit) mesi_q[s_idx][s_way] <= s_new;
      if (p_mesi_we) mesi_q[p_idx][p_way] <= p_new;
      if (p_plru_we) plru_q[p_idx] <= plru_touched;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && p_tag_we) tag_q[p_idx][p_way] <= p_tag;
  end

  assign proc_req_ready  = rst_n && (state_q == IDLE);
  assign proc_rsp_valid  = rst_n && (state_q == LOOKUP);
  assign proc_rsp_hit    = rst_n && rsp_hit;
  assign proc_rsp_way    = rst_n ? rsp_way : '0;
  assign proc_rsp_bus_op = rst_n ? rsp_op : 2'd0;
  assign proc_rsp_vdirty = rst_n && rsp_vdirty;
  assign proc_rsp_vtag   = rst_n ? rsp_vtag : '0;
  assign snoop_rsp_valid = rst_n && snp_vld_q;
  assign snoop_hit       = rst_n && snp_hit_q;
  assign snoop_flush     = rst_n && snp_flush_q;
  assign shared_local    = rst_n && snp_shared_q;

endmodule

// File: tb/tb_lv1_dl_mesi_tag_ctrl.sv
// Scoreboard bench for lv1_dl_mesi_tag_ctrl: expected lookup/snoop results
// are queued at stimulus time and popped when the DUT answers.
module tb_lv1_dl_mesi_tag_ctrl;

  localparam logic [1:0] OP_NONE = 2'd0, OP_RD = 2'd1, OP_RDX = 2'd2, OP_INV = 2'd3;

  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic [1:0]  op;
    logic        vdirty;
    logic        vtag_known;
    logic [17:0] vtag;
  } prsp_t;

  typedef struct packed {
    logic hit;
    logic flush;
    logic shared;
  } srsp_t;

  logic        clk, rst_n;
  logic        proc_req_valid, proc_req_ready, proc_req_wr;
  logic [31:0] proc_req_addr;
  logic        proc_rsp_valid, proc_rsp_hit, proc_rsp_vdirty;
  logic [1:0]  proc_rsp_way, proc_rsp_bus_op;
  logic [17:0] proc_rsp_vtag;
  logic        fill_valid, fill_shared, snoop_valid;
  logic [1:0]  snoop_op;
  logic [31:0] snoop_addr;
  logic        snoop_rsp_valid, snoop_hit, snoop_flush, shared_local;

  int vec_cnt = 0;
  int err_cnt = 0;
  prsp_t pq[$];
  srsp_t sq[$];

  lv1_dl_mesi_tag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .proc_req_valid(proc_req_valid), .proc_req_ready(proc_req_ready),
    .proc_req_wr(proc_req_wr), .proc_req_addr(proc_req_addr),
    .proc_rsp_valid(proc_rsp_valid), .proc_rsp_hit(proc_rsp_hit),
    .proc_rsp_way(proc_rsp_way), .proc_rsp_bus_op(proc_rsp_bus_op),
    .proc_rsp_vdirty(proc_rsp_vdirty), .proc_rsp_vtag(proc_rsp_vtag),
    .fill_valid(fill_valid), .fill_shared(fill_shared),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_rsp_valid(snoop_rsp_valid), .snoop_hit(snoop_hit),
    .snoop_flush(snoop_flush), .shared_local(shared_local)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_addr(input logic [17:0] t, input logic [7:0] idx);
    return {t, idx, 6'h00};
  endfunction

  function automatic prsp_t mk_rsp(input logic hit, input logic [1:0] way, input logic [1:0] op,
                                   input logic vd, input logic vk, input logic [17:0] vt);
    prsp_t r;
    r.hit = hit; r.way = way; r.op = op; r.vdirty = vd; r.vtag_known = vk; r.vtag = vt;
    return r;
  endfunction

  function automatic srsp_t mk_snp(input logic h, input logic f, input logic s);
    srsp_t r;
    r.hit = h; r.flush = f; r.shared = s;
    return r;
  endfunction

  always @(negedge clk) begin
    if (proc_rsp_valid) begin
      if (pq.size() == 0) chk_eq("proc_rsp_unexpected", proc_rsp_valid, 1'b0);
      else begin
        prsp_t e;
        e = pq.pop_front();
        chk_eq("rsp_hit", proc_rsp_hit, e.hit);
        chk_eq("rsp_way", proc_rsp_way, e.way);
        chk_eq("rsp_bus_op", proc_rsp_bus_op, e.op);
        chk_eq("rsp_vdirty", proc_rsp_vdirty, e.vdirty);
        if (e.vtag_known) chk_eq("rsp_vtag", proc_rsp_vtag, e.vtag);
      end
    end
    if (snoop_rsp_valid) begin
      if (sq.size() == 0) chk_eq("snoop_rsp_unexpected", snoop_rsp_valid, 1'b0);
      else begin
        srsp_t e;
        e = sq.pop_front();
        chk_eq("snoop_hit", snoop_hit, e.hit);
        chk_eq("snoop_flush", snoop_flush, e.flush);
        chk_eq("shared_local", shared_local, e.shared);
      end
    end
  end

  task automatic reset_check();
    chk_eq("rst_req_ready", proc_req_ready, 0);
    chk_eq("rst_rsp_valid", proc_rsp_valid, 0);
    chk_eq("rst_rsp_hit", proc_rsp_hit, 0);
    chk_eq("rst_rsp_way", proc_rsp_way, 0);
    chk_eq("rst_rsp_bus_op", proc_rsp_bus_op, 0);
    chk_eq("rst_rsp_vdirty", proc_rsp_vdirty, 0);
    chk_eq("rst_rsp_vtag", proc_rsp_vtag, 0);
    chk_eq("rst_snoop_rsp_valid", snoop_rsp_valid, 0);
    chk_eq("rst_snoop_hit", snoop_hit, 0);
    chk_eq("rst_snoop_flush", snoop_flush, 0);
    chk_eq("rst_shared_local", shared_local, 0);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic lookup(input logic wr, input logic [31:0] addr, input prsp_t e);
    int n;
    n = 0;
    while (!proc_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk_eq("req_ready", proc_req_ready, 1);
    pq.push_back(e);
    proc_req_valid = 1'b1; proc_req_wr = wr; proc_req_addr = addr;
    @(posedge clk); #1;
    proc_req_valid = 1'b0;
    n = 0;
    while (pq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    if (pq.size() != 0) begin chk_eq("proc_rsp_timeout", pq.size(), 0); pq.delete(); end
  endtask

  task automatic fill(input logic shared);
    fill_valid = 1'b1; fill_shared = shared;
    @(posedge clk); #1;
    fill_valid = 1'b0; fill_shared = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] op, input logic [31:0] addr, input srsp_t e,
                       input logic with_fill);
    int n;
    sq.push_back(e);
    snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
    fill_valid = with_fill; fill_shared = 1'b0;
    @(posedge clk); #1;
    snoop_valid = 1'b0; fill_valid = 1'b0;
    n = 0;
    while (sq.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
    if (sq.size() != 0) begin chk_eq("snoop_rsp_timeout", sq.size(), 0); sq.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, c, t4;
    rst_n = 1'b0; proc_req_valid = 1'b0; proc_req_wr = 1'b0; proc_req_addr = '0;
    fill_valid = 1'b0; fill_shared = 1'b0; snoop_valid = 1'b0; snoop_op = '0; snoop_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_check();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk_eq("ready_after_reset", proc_req_ready, 1);
    @(posedge clk); #1;

    a = mk_addr(18'd0, 8'h41);
    lookup(1'b0, a, mk_rsp(0, 2'd0, OP_RD, 0, 0, '0));
    fill(1'b0);
    lookup(1'b0, a, mk_rsp(1, 2'd0, OP_NONE, 0, 0, '0));
    lookup(1'b1, a, mk_rsp(1, 2'd0, OP_NONE, 0, 0, '0));
    snoop(OP_RD, a, mk_snp(1, 1, 1), 1'b0);
    lookup(1'b1, a, mk_rsp(0, 2'd0, OP_INV, 0, 0, '0));
    fill(1'b0);
    snoop(OP_RDX, a, mk_snp(1, 1, 0), 1'b0);
    lookup(1'b0, a, mk_rsp(0, 2'd0, OP_RD, 0, 1, 18'd0));
    fill(1'b1);
    snoop(OP_RD, a, mk_snp(1, 0, 1), 1'b0);
    snoop(OP_INV, a, mk_snp(1, 0, 0), 1'b0);
    snoop(OP_RD, a, mk_snp(0, 0, 0), 1'b0);

    // Reset while waiting for a fill.
    c = mk_addr(18'd7, 8'h41);
    lookup(1'b0, c, mk_rsp(0, 2'd0, OP_RD, 0, 1, 18'd0));
    rst_n = 1'b0;
    @(negedge clk); reset_check();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk_eq("ready_after_midop_reset", proc_req_ready, 1);
    @(posedge clk); #1;

    // Fill all four ways of set 0x41, way0 dirty, then force a PLRU eviction.
    lookup(1'b1, c, mk_rsp(0, 2'd0, OP_RDX, 0, 0, '0));
    fill(1'b0);
    for (int k = 1; k < 4; k++) begin
      lookup(1'b0, mk_addr(18'(7 + k), 8'h41), mk_rsp(0, 2'(k), OP_RD, 0, 0, '0));
      fill(1'b0);
    end
    t4 = mk_addr(18'd11, 8'h41);
    lookup(1'b0, t4, mk_rsp(0, 2'd0, OP_RD, 1, 1, 18'd7));
    snoop(OP_RDX, c, mk_snp(1, 1, 0), 1'b1);
    lookup(1'b0, t4, mk_rsp(1, 2'd0, OP_NONE, 0, 0, '0));
    snoop(OP_RD, t4, mk_snp(1, 0, 1), 1'b0);
    lookup(1'b0, c, mk_rsp(0, 2'd2, OP_RD, 0, 1, 18'd9));
    fill(1'b1);
    snoop(OP_RD, c, mk_snp(1, 0, 1), 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
